// File: rtl/oam_dma_controller_if.sv
// oam_dma_controller_if: bundles the CPU snoop, source-read and OAM-write
// signals of the OAM DMA engine.
//   master : the DMA engine itself
//   slave  : the system side (CPU bus, source memory, PPU MMU mux)
interface oam_dma_if;
   logic [15:0] cpu_A;        // CPU address
   logic [7:0]  cpu_Di;       // CPU write data
   logic        cpu_wr;       // CPU write strobe
   logic [7:0]  DMA;          // DMA register value for PPU MMU reads of 0xFF46
   logic [15:0] src_A;        // source read address
   logic        src_rd;       // source read strobe
   logic [7:0]  src_Di;       // source read data, one clock after src_rd
   logic [15:0] dma_A;        // OAM write address
   logic [7:0]  dma_Do;       // OAM write data
   logic        dma_wr;       // OAM write strobe
   logic        dma_active;   // engine owns the OAM bus (mux select)
   logic        cpu_blocked;  // current CPU access must be ignored

   modport master (
      input  cpu_A, cpu_Di, cpu_wr, src_Di,
      output DMA, src_A, src_rd, dma_A, dma_Do, dma_wr, dma_active, cpu_blocked
   );

   modport slave (
      output cpu_A, cpu_Di, cpu_wr, src_Di,
      input  DMA, src_A, src_rd, dma_A, dma_Do, dma_wr, dma_active, cpu_blocked
   );
endinterface

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: OAM DMA engine placed in front of the PPU MMU.
// A CPU write to 0xFF46 latches a source page; after a CPB-clock start delay
// the engine copies NBYTES bytes from {page,00..} into OAM 0xFE00.., one byte
// per CPB clocks. Writing 0xFF46 again at any time restarts from byte 0.
// Optional build macro DMA_HRAM_ONLY_EN: while transferring, the CPU is
// blocked everywhere except HRAM 0xFF80..0xFFFE and the 0xFF46 register.
// Without it, only CPU accesses to OAM 0xFE00..0xFE9F are blocked.
// CPB must lie in 2..16.
module oam_dma_controller #(
   parameter int CPB    = 4,
   parameter int NBYTES = 160
) (
   input  logic      clk,
   input  logic      reset,
   oam_dma_if.master bus
);

   localparam int              SUB_W        = $clog2(CPB);
   localparam logic [SUB_W-1:0] SUB_ZERO    = '0;
   localparam logic [SUB_W-1:0] SUB_ONE     = SUB_W'(1);
   localparam logic [SUB_W-1:0] SUB_LAST    = SUB_W'(CPB - 1);
   localparam logic [7:0]      IDX_LAST     = 8'(NBYTES - 1);
   localparam logic [15:0]     DMA_REG_ADDR = 16'hFF46;
   localparam logic [15:0]     OAM_BASE     = 16'hFE00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      XFER  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [SUB_W-1:0] sub_reg, sub_next;
   logic [7:0]       idx_reg, idx_next;
   logic [7:0]       dma_reg, dma_next;
   logic [7:0]       latch_reg;
   logic             cpu_blocked_reg;

   logic             trigger;
   logic [7:0]       page;
   logic [7:0]       wr_data;
   logic             rd_slot;
   logic             wr_slot;

   // CPU addresses that collide with an active transfer.
   function automatic logic addr_blocked(input logic [15:0] a);
`ifdef DMA_HRAM_ONLY_EN
      return !((a >= 16'hFF80) && (a <= 16'hFFFE)) && (a != DMA_REG_ADDR);
`else
      return (a >= 16'hFE00) && (a <= 16'hFE9F);
`endif
   endfunction

   assign trigger = bus.cpu_wr && (bus.cpu_A == DMA_REG_ADDR);

   // Echo RAM pages 0xE0..0xFF mirror 0xC0..0xDF; the register keeps the raw value.
   assign page = (dma_reg < 8'hE0) ? dma_reg : (dma_reg - 8'h20);

   // With CPB=2 the write slot coincides with the data-return slot, so the
   // byte is forwarded straight from the source bus instead of the latch.
   assign wr_data = (CPB == 2) ? bus.src_Di : latch_reg;

   assign rd_slot = (state_reg == XFER) && (sub_reg == SUB_ZERO);
   assign wr_slot = (state_reg == XFER) && (sub_reg == SUB_LAST);

   // Next-state logic: a 0xFF46 write overrides everything, including an
   // in-flight transfer and its final byte.
   always_comb begin
      state_next = state_reg;
      sub_next   = sub_reg;
      idx_next   = idx_reg;
      dma_next   = dma_reg;
      if (trigger) begin
         dma_next   = bus.cpu_Di;
         state_next = START;
         sub_next   = SUB_ZERO;
         idx_next   = 8'h00;
      end else begin
         case (state_reg)
            START: begin
               if (sub_reg == SUB_LAST) begin
                  state_next = XFER;
                  sub_next   = SUB_ZERO;
                  idx_next   = 8'h00;
               end else begin
                  sub_next = sub_reg + SUB_ONE;
               end
            end
            XFER: begin
               if (sub_reg == SUB_LAST) begin
                  sub_next = SUB_ZERO;
                  if (idx_reg == IDX_LAST) begin
                     state_next = IDLE;
                     idx_next   = 8'h00;
                  end else begin
                     idx_next = idx_reg + 8'h01;
                  end
               end else begin
                  sub_next = sub_reg + SUB_ONE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // State, counters and the DMA register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         sub_reg   <= SUB_ZERO;
         idx_reg   <= 8'h00;
         dma_reg   <= 8'h00;
      end else begin
         state_reg <= state_next;
         sub_reg   <= sub_next;
         idx_reg   <= idx_next;
         dma_reg   <= dma_next;
      end
   end

   // Capture the source byte in the slot after the read strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         latch_reg <= 8'h00;
      end else if ((state_reg == XFER) && (sub_reg == SUB_ONE)) begin
         latch_reg <= bus.src_Di;
      end
   end

   // CPU blocking is registered so no output has a combinational path from
   // the CPU bus; it reflects the address presented in the previous clock.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_blocked_reg <= 1'b0;
      end else begin
         cpu_blocked_reg <= (state_next == XFER) && addr_blocked(bus.cpu_A);
      end
   end

   // Bus outputs decoded from registered state; idle values are zero.
   always_comb begin
      bus.DMA         = dma_reg;
      bus.dma_active  = (state_reg == XFER);
      bus.cpu_blocked = cpu_blocked_reg;
      bus.src_rd      = 1'b0;
      bus.src_A       = 16'h0000;
      bus.dma_wr      = 1'b0;
      bus.dma_A       = 16'h0000;
      bus.dma_Do      = 8'h00;
      if (rd_slot) begin
         bus.src_rd = 1'b1;
         bus.src_A  = {page, idx_reg};
      end
      if (wr_slot) begin
         bus.dma_wr = 1'b1;
         bus.dma_A  = OAM_BASE + {8'h00, idx_reg};
         bus.dma_Do = wr_data;
      end
   end

endmodule
